// File: rtl/hdmi_pattern_gen.sv
// Test-pattern source for an HDMI transmitter. It follows the transceiver's de/addr
// stream and produces one registered RGB pixel per active cycle.
module hdmi_pattern_gen #(
    parameter int H_PIXEL   = 640,
    parameter int V_PIXEL   = 480,
    parameter int COLOR_W   = 8,
    parameter int BAR_COUNT = 8,
    parameter int CHK_LOG2  = 4
) (
    input  logic               pixclk,
    input  logic               reset,
    input  logic               de,
    input  logic [20:0]        addr,
    input  logic [2:0]         mode,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [15:0]        frame_cnt,
    output logic [2:0]         mode_active
);

    localparam int XW  = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
    localparam int YW  = (V_PIXEL > 1) ? $clog2(V_PIXEL) : 1;
    localparam int BW  = H_PIXEL / BAR_COUNT;
    localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
    localparam int PW  = XW + 6;
    localparam logic [20:0] HALF_ADDR = 21'(H_PIXEL * V_PIXEL / 2);

    typedef enum logic [2:0] {
        PAT_SOLID   = 3'd0,
        PAT_SPLIT   = 3'd1,
        PAT_BARS    = 3'd2,
        PAT_CHECKER = 3'd3,
        PAT_GRAD    = 3'd4,
        PAT_MOVBAR  = 3'd5
    } pattern_e;

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [BCW-1:0]     bar_cnt_q, bar_cnt_d;
    logic [XW-1:0]      pos_q, pos_d;
    logic [2:0]         mode_active_q, mode_active_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               frame_valid_q, frame_valid_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    // Values seen by the pixel of this cycle; a frame start overrides the registers.
    logic           frame_start;
    logic [XW-1:0]  x_cur;
    logic [YW-1:0]  y_cur;
    logic [2:0]     bar_idx_cur;
    logic [BCW-1:0] bar_cnt_cur;
    logic [XW-1:0]  pos_cur;
    logic [XW:0]    pos_step;
    logic [XW:0]    pos_wrap;
    logic [2:0]     mode_cur;
    logic           x_last;
    logic           y_last;
    logic [PW-1:0]  x_ext;
    logic [PW-1:0]  pos_ext;
    logic           r_on, g_on, b_on;

    always_comb begin
        frame_start = de && (addr == '0);
        x_cur       = frame_start ? '0 : x_q;
        y_cur       = frame_start ? '0 : y_q;
        bar_idx_cur = frame_start ? '0 : bar_idx_q;
        bar_cnt_cur = frame_start ? '0 : bar_cnt_q;
        mode_cur    = frame_start ? mode : mode_active_q;
        x_last      = (x_cur == XW'(H_PIXEL - 1));
        y_last      = (y_cur == YW'(V_PIXEL - 1));

        // The moving-bar origin tracks frame_cnt*4 mod H_PIXEL incrementally, so no
        // modulo hardware is needed; it returns to 0 with frame_cnt's own wrap.
        pos_step = {1'b0, pos_q} + (XW+1)'(4);
        pos_wrap = (pos_step >= (XW+1)'(H_PIXEL)) ? pos_step - (XW+1)'(H_PIXEL) : pos_step;
        if (!frame_start) begin
            pos_cur = pos_q;
        end else if (frame_cnt_q == 16'hFFFF) begin
            pos_cur = '0;
        end else begin
            pos_cur = XW'(pos_wrap);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        x_d           = x_q;
        y_d           = y_q;
        bar_idx_d     = bar_idx_q;
        bar_cnt_d     = bar_cnt_q;
        pos_d         = pos_cur;
        mode_active_d = mode_cur;
        frame_cnt_d   = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
        frame_valid_d = frame_valid_q | frame_start;

        if (de) begin
            if (x_last) begin
                x_d       = '0;
                bar_idx_d = '0;
                bar_cnt_d = '0;
                y_d       = y_last ? '0 : y_cur + YW'(1);
            end else begin
                x_d = x_cur + XW'(1);
                y_d = y_cur;
                if (bar_cnt_cur == BCW'(BW - 1)) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_cur + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_cur + BCW'(1);
                    bar_idx_d = bar_idx_cur;
                end
            end
        end
    end

    always_comb begin
        x_ext   = PW'(x_cur);
        pos_ext = PW'(pos_cur);
        r_on    = 1'b0;
        g_on    = 1'b0;
        b_on    = 1'b0;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;

        if (de && (frame_valid_q || frame_start)) begin
            case (mode_cur)
                PAT_SOLID: r_on = 1'b1;
                PAT_SPLIT: begin
                    r_on = (addr < HALF_ADDR);
                    b_on = !(addr < HALF_ADDR);
                end
                PAT_BARS: begin
                    case (bar_idx_cur)
                        3'd0: {r_on, g_on, b_on} = 3'b111;
                        3'd1: {r_on, g_on, b_on} = 3'b110;
                        3'd2: {r_on, g_on, b_on} = 3'b011;
                        3'd3: {r_on, g_on, b_on} = 3'b010;
                        3'd4: {r_on, g_on, b_on} = 3'b101;
                        3'd5: {r_on, g_on, b_on} = 3'b100;
                        3'd6: {r_on, g_on, b_on} = 3'b001;
                        default: {r_on, g_on, b_on} = 3'b000;
                    endcase
                end
                PAT_CHECKER: begin
                    r_on = x_ext[CHK_LOG2] ^ y_cur[CHK_LOG2];
                    g_on = r_on;
                    b_on = r_on;
                end
                PAT_MOVBAR: begin
                    r_on = (x_ext >= pos_ext) && (x_ext < pos_ext + PW'(16));
                    g_on = r_on;
                    b_on = r_on;
                end
                default: ;
            endcase

            if (mode_cur == PAT_GRAD) begin
                red_d   = x_ext[COLOR_W-1:0];
                green_d = x_ext[COLOR_W-1:0];
                blue_d  = x_ext[COLOR_W-1:0];
            end else begin
                red_d   = {COLOR_W{r_on}};
                green_d = {COLOR_W{g_on}};
                blue_d  = {COLOR_W{b_on}};
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            bar_idx_q     <= '0;
            bar_cnt_q     <= '0;
            pos_q         <= '0;
            mode_active_q <= '0;
            frame_cnt_q   <= '0;
            frame_valid_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            bar_idx_q     <= bar_idx_d;
            bar_cnt_q     <= bar_cnt_d;
            pos_q         <= pos_d;
            mode_active_q <= mode_active_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_valid_q <= frame_valid_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_cnt   = frame_cnt_q;
    assign mode_active = mode_active_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen: the driver queues the hand-computed pixel
// expected for each cycle and a monitor compares it one clock later.
module tb_hdmi_pattern_gen;

    logic        pixclk = 1'b0;
    logic        reset = 1'b1;
    logic        de = 1'b0;
    logic [20:0] addr = '0;
    logic [2:0]  mode = '0;
    logic [7:0]  red, green, blue;
    logic [15:0] frame_cnt;
    logic [2:0]  mode_active;

    always #5 pixclk = ~pixclk;

    hdmi_pattern_gen dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .de          (de),
        .addr        (addr),
        .mode        (mode),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_cnt   (frame_cnt),
        .mode_active (mode_active)
    );

    typedef struct {
        logic        chk_rgb;
        logic [23:0] rgb;
        logic        chk_st;
        logic [15:0] fc;
        logic [2:0]  ma;
        string       nm;
    } exp_t;

    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] WHT = 24'hFFFFFF;
    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] BLU = 24'h0000FF;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          chk_at[$];
    logic [23:0] chk_val[$];

    task automatic drive(input logic r, input logic d, input int a, input logic [2:0] m,
                         input exp_t e);
        @(negedge pixclk);
        reset = r;
        de    = d;
        addr  = 21'(a);
        mode  = m;
        sb.push_back(e);
    endtask

    task automatic pix(input logic d, input int a, input logic [2:0] m);
        exp_t e;
        e.chk_rgb = 1'b0; e.rgb = '0; e.chk_st = 1'b0; e.fc = '0; e.ma = '0; e.nm = "";
        drive(1'b0, d, a, m, e);
    endtask

    task automatic pchk(input logic d, input int a, input logic [2:0] m,
                        input logic [23:0] rgb, input string nm);
        exp_t e;
        e.chk_rgb = 1'b1; e.rgb = rgb; e.chk_st = 1'b0; e.fc = '0; e.ma = '0; e.nm = nm;
        drive(1'b0, d, a, m, e);
    endtask

    task automatic pst(input logic r, input logic d, input int a, input logic [2:0] m,
                       input logic [23:0] rgb, input logic [15:0] fc, input logic [2:0] ma,
                       input string nm);
        exp_t e;
        e.chk_rgb = 1'b1; e.rgb = rgb; e.chk_st = 1'b1; e.fc = fc; e.ma = ma; e.nm = nm;
        drive(r, d, a, m, e);
    endtask

    task automatic expect_at(input int a, input logic [23:0] v);
        chk_at.push_back(a);
        chk_val.push_back(v);
    endtask

    // Contiguous de=1 run over addresses a0..a0+n-1, checking only the listed addresses.
    task automatic run_span(input int a0, input int n, input logic [2:0] m, input string nm);
        for (int i = 0; i < n; i++) begin
            int a;
            int hit;
            a   = a0 + i;
            hit = -1;
            foreach (chk_at[k]) if (chk_at[k] == a) hit = k;
            if (hit >= 0) pchk(1'b1, a, m, chk_val[hit], $sformatf("%s_a%0d", nm, a));
            else          pix(1'b1, a, m);
        end
        chk_at.delete();
        chk_val.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge pixclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_rgb) begin
                    total++;
                    if ({red, green, blue} !== e.rgb) begin
                        bad++;
                        $display("FAIL %s rgb got=%06h want=%06h", e.nm, {red, green, blue}, e.rgb);
                    end
                end
                if (e.chk_st) begin
                    total++;
                    if (frame_cnt !== e.fc || mode_active !== e.ma) begin
                        bad++;
                        $display("FAIL %s status got fc=%0d ma=%0d want fc=%0d ma=%0d",
                                 e.nm, frame_cnt, mode_active, e.fc, e.ma);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int w;

        // Reset, including a frame-start pattern that reset must override.
        pst(1'b1, 1'b0, 0, 3'd0, BLK, 16'd0, 3'd0, "rst0");
        pst(1'b1, 1'b0, 0, 3'd0, BLK, 16'd0, 3'd0, "rst1");
        pst(1'b1, 1'b1, 0, 3'd3, BLK, 16'd0, 3'd0, "rst_vs_fs");
        pchk(1'b0, 0, 3'd0, BLK, "idle_de0");
        pst(1'b0, 1'b1, 7, 3'd2, BLK, 16'd0, 3'd0, "pre_frame");

        // Mode 0 solid red.
        pst(1'b0, 1'b1, 0, 3'd0, RED, 16'd1, 3'd0, "m0_first");
        pchk(1'b0, 1, 3'd0, BLK, "m0_gap");
        pchk(1'b1, 1, 3'd0, RED, "m0_x1");
        pst(1'b0, 1'b0, 2, 3'd0, BLK, 16'd1, 3'd0, "m0_hold");

        // Mode 1 split at the half-frame address.
        pst(1'b0, 1'b1, 0, 3'd1, RED, 16'd2, 3'd1, "m1_first");
        pchk(1'b1, 153599, 3'd1, RED, "m1_153599");
        pchk(1'b1, 153600, 3'd1, BLU, "m1_153600");
        pchk(1'b1, 307199, 3'd1, BLU, "m1_last");

        // Mode 2 colour bars, with a de=0 gap just before a bar edge.
        pst(1'b0, 1'b1, 0, 3'd2, WHT, 16'd3, 3'd2, "bar_x0");
        expect_at(79, WHT);
        run_span(1, 79, 3'd2, "bar");
        pchk(1'b0, 80, 3'd2, BLK, "bar_gap");
        expect_at(80, 24'hFFFF00);
        expect_at(160, 24'h00FFFF);
        expect_at(559, BLU);
        expect_at(560, BLK);
        expect_at(639, BLK);
        expect_at(640, WHT);
        run_span(80, 561, 3'd2, "bar");

        // Mode 3 checkerboard over the first 16 lines.
        pst(1'b0, 1'b1, 0, 3'd3, BLK, 16'd4, 3'd3, "chk_00");
        expect_at(15, BLK);
        expect_at(16, WHT);
        expect_at(31, WHT);
        expect_at(32, BLK);
        expect_at(16 * 640, WHT);
        expect_at(16 * 640 + 16, BLK);
        run_span(1, 16 * 640 + 16, 3'd3, "chk");

        // Mode requested changes mid-frame: ignored until the next frame start.
        pst(1'b0, 1'b1, 0, 3'd0, RED, 16'd5, 3'd0, "sw_first");
        expect_at(500, RED);
        run_span(1, 999, 3'd0, "sw");
        expect_at(1000, RED);
        expect_at(1599, RED);
        run_span(1000, 600, 3'd4, "sw");
        pst(1'b0, 1'b0, 1600, 3'd4, BLK, 16'd5, 3'd0, "sw_ma_hold");

        // Mode 4 gradient.
        pst(1'b0, 1'b1, 0, 3'd4, BLK, 16'd6, 3'd4, "grad_x0");
        expect_at(1, 24'h010101);
        expect_at(255, WHT);
        expect_at(256, BLK);
        expect_at(300, 24'h2C2C2C);
        run_span(1, 300, 3'd4, "grad");

        // Mode 6 is black; mode 7 requested mid-frame stays ignored.
        pst(1'b0, 1'b1, 0, 3'd6, BLK, 16'd7, 3'd6, "m6_first");
        pchk(1'b1, 1, 3'd7, BLK, "m6_x1");

        // Mode 5 with frame_cnt=8: bar covers x=32..47.
        pst(1'b0, 1'b1, 0, 3'd5, BLK, 16'd8, 3'd5, "mb_x0");
        expect_at(31, BLK);
        expect_at(32, WHT);
        expect_at(47, WHT);
        expect_at(48, BLK);
        run_span(1, 4999, 3'd5, "mb");

        // Reset mid-frame, then black until the next frame start.
        pst(1'b1, 1'b1, 5000, 3'd5, BLK, 16'd0, 3'd0, "rst_mid");
        expect_at(5001, BLK);
        expect_at(5005, BLK);
        run_span(5001, 10, 3'd5, "post_rst");
        pst(1'b0, 1'b1, 0, 3'd5, BLK, 16'd1, 3'd5, "mb2_x0");
        expect_at(3, BLK);
        expect_at(4, WHT);
        expect_at(19, WHT);
        expect_at(20, BLK);
        run_span(1, 20, 3'd5, "mb2");

        // Back-to-back frame starts up to frame_cnt=158: bar at 632, truncated at 639.
        for (int k = 0; k < 156; k++) pix(1'b1, 0, 3'd5);
        pst(1'b0, 1'b1, 0, 3'd5, BLK, 16'd158, 3'd5, "mb3_x0");
        expect_at(631, BLK);
        expect_at(632, WHT);
        expect_at(639, WHT);
        expect_at(640, BLK);
        run_span(1, 640, 3'd5, "mb3");

        pix(1'b0, 0, 3'd0);
        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(posedge pixclk);
            w++;
        end
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_pattern_gen.md
HDMI_PATTERN_GEN -- requirements
Module: hdmi_pattern_gen

Interface
REQ-001 Parameter H_PIXEL, default 640, active pixels per line; SHALL be a multiple of BAR_COUNT.
REQ-002 Parameter V_PIXEL, default 480, active lines per frame.
REQ-003 Parameter COLOR_W, default 8, bits per colour channel.
REQ-004 Parameter BAR_COUNT, default 8, number of colour-bar columns; fixed at 8 in this revision.
REQ-005 Parameter CHK_LOG2, default 4, log2 of checkerboard square size in pixels.
REQ-006 pixclk  input  1  pixel clock; the block's only clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 de  input  1  active-video qualifier from the HDMI transceiver.
REQ-009 addr  input  21  linear active-pixel address from the transceiver; valid only while de=1.
REQ-010 mode  input  3  requested pattern; sampled only at frame start.
REQ-011 red, green, blue  output  COLOR_W each  registered pixel colour.
REQ-012 frame_cnt  output  16  count of frame starts since reset.
REQ-013 mode_active  output  3  pattern mode latched for the current frame.

Function
REQ-014 Frame start SHALL be the cycle with de=1 and addr=0.
REQ-015 At frame start: x<=1, y<=0, mode_active<=mode, frame_cnt<=frame_cnt+1 (wraps 0xFFFF->0), frame_valid<=1; the pixel for this cycle uses x=0, y=0 and the new mode.
REQ-016 Other cycles with de=1: x increments; at x=H_PIXEL-1, x<=0 and y increments; at y=V_PIXEL-1 with the line wrap, y<=0.
REQ-017 Cycles with de=0: x, y, mode_active and frame_cnt SHALL hold.
REQ-018 Latency: colour SHALL appear on red/green/blue exactly 1 pixclk after the de/addr cycle it belongs to.
REQ-019 Outputs for a de=0 cycle, or any cycle while frame_valid=0, SHALL be all zero.
REQ-020 Max value M = 2^COLOR_W-1.
REQ-021 Mode 0 solid: (M,0,0).
REQ-022 Mode 1 split: addr < H_PIXEL*V_PIXEL/2 gives (M,0,0); otherwise (0,0,M).
REQ-023 Mode 2 bars: bar index = x / (H_PIXEL/8), computed with a bar-width counter, no divider; indices 0..7 give white, yellow, cyan, green, magenta, red, blue, black (each channel M or 0).
REQ-024 Mode 3 checker: x[CHK_LOG2] XOR y[CHK_LOG2]; 1 gives (M,M,M), 0 gives (0,0,0).
REQ-025 Mode 4 gradient: all three channels = x[COLOR_W-1:0]; wraps modulo 2^COLOR_W across the line.
REQ-026 Mode 5 moving bar: position p = (frame_cnt*4) mod H_PIXEL; pixels with p <= x < p+16 give white, all others black; no wrap at the right edge, so the bar is truncated there.
REQ-027 Modes 6 and 7 SHALL output black while de=1.
REQ-028 A change on mode mid-frame SHALL have no effect until the next frame start.
REQ-029 de=1 with addr=0 mid-frame SHALL be treated as a frame start; the transceiver is authoritative.

Reset
REQ-030 While reset=1: red, green and blue=0; frame_cnt=0; mode_active=0; x=0, y=0; frame_valid=0.
REQ-031 Reset SHALL take priority over a simultaneous frame start.
REQ-032 After reset deasserts, outputs SHALL stay black until the first frame start, including if reset occurred mid-frame.

Verification
REQ-033 Reset, then one frame with mode=0 -> first pixel at t+1 is (255,0,0); frame_cnt=1; de=0 cycles give 0.
REQ-034 mode=1, H=640, V=480 -> addr 153599 gives (255,0,0); addr 153600 gives (0,0,255).
REQ-035 mode=2 -> x=0 white, x=79 white, x=80 yellow, x=559 blue, x=560 black, x=639 black.
REQ-036 mode=3 -> (x=15, y=0) black; (x=16, y=0) white; (x=16, y=16) black.
REQ-037 mode switched 0->4 at addr 1000 -> rest of frame stays solid red; next frame x=255 gives (255,255,255), x=256 gives (0,0,0).
REQ-038 Reset asserted at addr 5000 of a mode-5 frame -> outputs 0 and frame_cnt=0; black until the next addr=0 with de=1; on frame_cnt=1, bar at x=4..19.
